// File: rtl/id_stage_scoreboard_if.sv
// Decode-stage bus: fetch handoff, control-unit decode info, bypass/write-back ports
// and the operands/handshake the stage returns.
interface id_stage_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int MAX_LAT = 4
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_LAT + 1);

    logic            i_valid;
    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_inst;
    logic            i_flush;
    logic            i_hold;
    logic [AW-1:0]   i_ctl_ra1, i_ctl_ra2;
    logic            i_ctl_use1, i_ctl_use2;
    logic            i_ctl_we;
    logic [AW-1:0]   i_ctl_wa;
    logic [CW-1:0]   i_ctl_lat;
    logic            i_e_we, i_m_we, i_w_we;
    logic [AW-1:0]   i_e_wa, i_m_wa, i_w_wa;
    logic [XLEN-1:0] i_e_data, i_m_data, i_w_data;
    logic            o_valid;
    logic [XLEN-1:0] o_pc;
    logic [31:0]     o_inst;
    logic [XLEN-1:0] o_rd1, o_rd2;
    logic [1:0]      o_fwd1, o_fwd2;
    logic            o_stall;
    logic            o_issue;

    modport master (
        output i_valid, i_pc, i_inst, i_flush, i_hold,
               i_ctl_ra1, i_ctl_ra2, i_ctl_use1, i_ctl_use2, i_ctl_we, i_ctl_wa, i_ctl_lat,
               i_e_we, i_m_we, i_w_we, i_e_wa, i_m_wa, i_w_wa, i_e_data, i_m_data, i_w_data,
        input  o_valid, o_pc, o_inst, o_rd1, o_rd2, o_fwd1, o_fwd2, o_stall, o_issue
    );

    modport slave (
        input  i_valid, i_pc, i_inst, i_flush, i_hold,
               i_ctl_ra1, i_ctl_ra2, i_ctl_use1, i_ctl_use2, i_ctl_we, i_ctl_wa, i_ctl_lat,
               i_e_we, i_m_we, i_w_we, i_e_wa, i_m_wa, i_w_wa, i_e_data, i_m_data, i_w_data,
        output o_valid, o_pc, o_inst, o_rd1, o_rd2, o_fwd1, o_fwd2, o_stall, o_issue
    );
endinterface

// File: rtl/id_stage_scoreboard.sv
// Decode stage: IF/ID register, register file, E/M/W bypass and a per-register
// latency scoreboard that pauses consumers of multi-cycle producers.
module id_stage_scoreboard #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int MAX_LAT = 4
) (
    input logic              clk,
    input logic              rstn,
    id_stage_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_LAT + 1);

    logic                       valid_q, valid_d;
    logic [XLEN-1:0]            pc_q, pc_d;
    logic [31:0]                inst_q, inst_d;
    logic [NREG-1:0][XLEN-1:0]  rf_q;
    logic [NREG-1:0][CW-1:0]    cnt_q, cnt_d;
    logic [1:0][AW-1:0]         ra;
    logic [1:0][XLEN-1:0]       rd;
    logic [1:0][1:0]            src;
    logic                       busy1, busy2, hazard, stall, issue;
    logic [CW-1:0]              lat_sat;

    assign busy1  = bus.i_ctl_use1 && (bus.i_ctl_ra1 != '0) && (cnt_q[bus.i_ctl_ra1] != '0);
    assign busy2  = bus.i_ctl_use2 && (bus.i_ctl_ra2 != '0) && (cnt_q[bus.i_ctl_ra2] != '0);
    assign hazard = valid_q && (busy1 || busy2);
    assign stall  = hazard || (valid_q && bus.i_hold);
    assign issue  = valid_q && !hazard && !bus.i_hold && !bus.i_flush;

    assign lat_sat = (bus.i_ctl_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : bus.i_ctl_lat;

    // Youngest producer wins; W covers the same-cycle write not yet in rf_q.
    assign ra[0] = bus.i_ctl_ra1;
    assign ra[1] = bus.i_ctl_ra2;
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rd[k]  = '0;
            src[k] = 2'd0;
            if (ra[k] != '0) begin
                if (bus.i_e_we && bus.i_e_wa == ra[k]) begin
                    rd[k]  = bus.i_e_data;
                    src[k] = 2'd1;
                end else if (bus.i_m_we && bus.i_m_wa == ra[k]) begin
                    rd[k]  = bus.i_m_data;
                    src[k] = 2'd2;
                end else if (bus.i_w_we && bus.i_w_wa == ra[k]) begin
                    rd[k]  = bus.i_w_data;
                    src[k] = 2'd3;
                end else begin
                    rd[k]  = rf_q[ra[k]];
                end
            end
        end
    end

    // A new issue overrides the running count: the younger writer defines availability.
    always_comb begin
        for (int r = 0; r < NREG; r++)
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
        if (issue && bus.i_ctl_we && bus.i_ctl_wa != '0 && lat_sat != '0)
            cnt_d[bus.i_ctl_wa] = lat_sat;
    end

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (bus.i_flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = '0;
        end else if (!stall) begin
            valid_d = bus.i_valid;
            pc_d    = bus.i_pc;
            inst_d  = bus.i_inst;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rf_q <= '0;
        else if (bus.i_w_we && bus.i_w_wa != '0)
            rf_q[bus.i_w_wa] <= bus.i_w_data;
    end

    assign bus.o_valid = valid_q;
    assign bus.o_pc    = pc_q;
    assign bus.o_inst  = inst_q;
    assign bus.o_rd1   = rd[0];
    assign bus.o_rd2   = rd[1];
    assign bus.o_fwd1  = src[0];
    assign bus.o_fwd2  = src[1];
    assign bus.o_stall = stall;
    assign bus.o_issue = issue;
endmodule

// File: tb/tb_id_stage_scoreboard.sv
// Decode-stage bench: directed hazard/forwarding scenarios plus random traffic, all
// checked against a ready-time model (register r is readable from cycle ready[r]).
module tb_id_stage_scoreboard;
    localparam int XLEN = 32, NREG = 32, MAX_LAT = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    id_stage_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .MAX_LAT(MAX_LAT)) bus();
    id_stage_scoreboard #(.XLEN(XLEN), .NREG(NREG), .MAX_LAT(MAX_LAT)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    // Reference model
    int          cyc = 0;
    int          ready[NREG];
    logic [31:0] mrf[NREG];
    logic        mv;
    logic [31:0] mpc, minst;

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            ready[r] = 0;
            mrf[r]   = '0;
        end
        mv = 1'b0; mpc = '0; minst = '0;
    endtask

    function automatic bit pend(input int r);
        return r != 0 && cyc < ready[r];
    endfunction

    task automatic exp_op(input int r, output logic [31:0] d, output logic [1:0] s);
        d = '0; s = 2'd0;
        if (r == 0) return;
        if (bus.i_e_we && bus.i_e_wa == r)      begin d = bus.i_e_data; s = 2'd1; end
        else if (bus.i_m_we && bus.i_m_wa == r) begin d = bus.i_m_data; s = 2'd2; end
        else if (bus.i_w_we && bus.i_w_wa == r) begin d = bus.i_w_data; s = 2'd3; end
        else d = mrf[r];
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        bit haz, stl, iss;
        logic [31:0] d1, d2;
        logic [1:0]  s1, s2;
        int lat;
        #1;
        haz = mv && ((bus.i_ctl_use1 && pend(int'(bus.i_ctl_ra1))) ||
                     (bus.i_ctl_use2 && pend(int'(bus.i_ctl_ra2))));
        stl = haz || (mv && bus.i_hold);
        iss = mv && !haz && !bus.i_hold && !bus.i_flush;
        exp_op(int'(bus.i_ctl_ra1), d1, s1);
        exp_op(int'(bus.i_ctl_ra2), d2, s2);
        chk("valid", bus.o_valid, mv);
        chk("pc",    bus.o_pc,    mpc);
        chk("inst",  bus.o_inst,  minst);
        chk("stall", bus.o_stall, stl);
        chk("issue", bus.o_issue, iss);
        chk("rd1",   bus.o_rd1,   d1);
        chk("fwd1",  bus.o_fwd1,  s1);
        chk("rd2",   bus.o_rd2,   d2);
        chk("fwd2",  bus.o_fwd2,  s2);
        if (iss && bus.i_ctl_we && bus.i_ctl_wa != 0 && bus.i_ctl_lat != 0) begin
            lat = (int'(bus.i_ctl_lat) > MAX_LAT) ? MAX_LAT : int'(bus.i_ctl_lat);
            ready[bus.i_ctl_wa] = cyc + lat + 1;
        end
        if (bus.i_w_we && bus.i_w_wa != 0) mrf[bus.i_w_wa] = bus.i_w_data;
        if (bus.i_flush) begin
            mv = 1'b0; mpc = '0; minst = '0;
        end else if (!stl) begin
            mv = bus.i_valid; mpc = bus.i_pc; minst = bus.i_inst;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_valid = 0; bus.i_pc = '0; bus.i_inst = '0; bus.i_flush = 0; bus.i_hold = 0;
        bus.i_ctl_ra1 = '0; bus.i_ctl_ra2 = '0; bus.i_ctl_use1 = 0; bus.i_ctl_use2 = 0;
        bus.i_ctl_we = 0; bus.i_ctl_wa = '0; bus.i_ctl_lat = '0;
        bus.i_e_we = 0; bus.i_m_we = 0; bus.i_w_we = 0;
        bus.i_e_wa = '0; bus.i_m_wa = '0; bus.i_w_wa = '0;
        bus.i_e_data = '0; bus.i_m_data = '0; bus.i_w_data = '0;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.i_valid = 1; bus.i_pc = pc; bus.i_inst = pc ^ 32'h0000_0013;
    endtask

    task automatic ctl(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2,
                       input logic we, input logic [4:0] wa, input logic [2:0] lat);
        bus.i_ctl_use1 = u1; bus.i_ctl_ra1 = r1; bus.i_ctl_use2 = u2; bus.i_ctl_ra2 = r2;
        bus.i_ctl_we = we; bus.i_ctl_wa = wa; bus.i_ctl_lat = lat;
    endtask

    // Steps until the instruction in IF/ID issues; returns the stall cycles seen.
    task automatic count_stalls(output int n);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.o_issue) break;
            n++;
            step();
        end
        step();
    endtask

    task automatic rnd();
        bus.i_valid    = ($urandom_range(0, 3) != 0);
        bus.i_pc       = $urandom;
        bus.i_inst     = $urandom;
        bus.i_flush    = ($urandom_range(0, 15) == 0);
        bus.i_hold     = ($urandom_range(0, 7) == 0);
        bus.i_ctl_ra1  = 5'($urandom_range(0, 7));
        bus.i_ctl_ra2  = 5'($urandom_range(0, 7));
        bus.i_ctl_use1 = 1'($urandom_range(0, 1));
        bus.i_ctl_use2 = 1'($urandom_range(0, 1));
        bus.i_ctl_we   = 1'($urandom_range(0, 1));
        bus.i_ctl_wa   = 5'($urandom_range(0, 7));
        bus.i_ctl_lat  = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        bus.i_e_we     = 1'($urandom_range(0, 1));
        bus.i_m_we     = 1'($urandom_range(0, 1));
        bus.i_w_we     = 1'($urandom_range(0, 1));
        bus.i_e_wa     = 5'($urandom_range(0, 7));
        bus.i_m_wa     = 5'($urandom_range(0, 7));
        bus.i_w_wa     = 5'($urandom_range(0, 7));
        bus.i_e_data   = $urandom;
        bus.i_m_data   = $urandom;
        bus.i_w_data   = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int n;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_inst",  bus.o_inst,  0);
        step();

        // Load-use: one bubble, then the load result comes off the M bypass
        fetch(32'h100); step();
        fetch(32'h104); ctl(0, 0, 0, 0, 1, 8, 1); step();
        fetch(32'h108); ctl(1, 8, 0, 0, 0, 0, 0);
        #1;
        chk("lu_stall", bus.o_stall, 1);
        chk("lu_issue0", bus.o_issue, 0);
        step();
        bus.i_m_we = 1; bus.i_m_wa = 8; bus.i_m_data = 32'h1234_5678;
        #1;
        chk("lu_stall_end", bus.o_stall, 0);
        chk("lu_pc_held", bus.o_pc, 32'h104);
        chk("lu_fwd1", bus.o_fwd1, 2);
        chk("lu_rd1", bus.o_rd1, 32'h1234_5678);
        chk("lu_issue", bus.o_issue, 1);
        step();

        // Forwarding priority on r3
        ctl(1, 3, 0, 0, 0, 0, 0);
        bus.i_e_we = 1; bus.i_e_wa = 3; bus.i_e_data = 32'hA;
        bus.i_m_we = 1; bus.i_m_wa = 3; bus.i_m_data = 32'hB;
        bus.i_w_we = 1; bus.i_w_wa = 3; bus.i_w_data = 32'hC;
        #1; chk("fp_e", bus.o_rd1, 32'hA); chk("fp_e_src", bus.o_fwd1, 1);
        bus.i_e_we = 0;
        #1; chk("fp_m", bus.o_rd1, 32'hB); chk("fp_m_src", bus.o_fwd1, 2);
        bus.i_m_we = 0;
        #1; chk("fp_w", bus.o_rd1, 32'hC); chk("fp_w_src", bus.o_fwd1, 3);
        step();
        bus.i_e_we = 1; bus.i_m_we = 1; bus.i_ctl_ra1 = 5'd0;
        #1; chk("fp_r0", bus.o_rd1, 0); chk("fp_r0_src", bus.o_fwd1, 0);
        step();
        bus.i_e_we = 0; bus.i_m_we = 0; bus.i_w_we = 0;

        // WAW: lat-0 rewrite keeps the count; a later lat-2 rewrite extends it
        fetch(32'h200);
        ctl(0, 0, 0, 0, 1, 4, 3); step();
        ctl(0, 0, 0, 0, 1, 4, 0); step();
        ctl(1, 4, 0, 0, 0, 0, 0);
        #1; chk("waw_kept", bus.o_stall, 1);
        step();
        ctl(0, 0, 0, 0, 1, 4, 2); step();
        ctl(1, 4, 0, 0, 0, 0, 0);
        count_stalls(n);
        chk("waw_stalls", n, 2);

        // Flush while stalled: bubble loaded, count keeps running
        ctl(0, 0, 0, 0, 1, 9, 4); step();
        ctl(1, 9, 0, 0, 0, 0, 0); bus.i_flush = 1;
        #1; chk("fl_issue", bus.o_issue, 0); chk("fl_stall", bus.o_stall, 1);
        step();
        bus.i_flush = 0;
        #1; chk("fl_valid", bus.o_valid, 0); chk("fl_inst", bus.o_inst, 0);
        step();
        count_stalls(n);
        chk("fl_cnt_stalls", n, 2);

        // Hold: IF/ID frozen, W still writes r7 and the held reader sees it
        ctl(1, 7, 0, 0, 0, 0, 0); fetch(32'h300); step();
        fetch(32'h304); bus.i_hold = 1;
        bus.i_w_we = 1; bus.i_w_wa = 7; bus.i_w_data = 32'h77;
        #1; chk("hold_stall", bus.o_stall, 1); chk("hold_issue", bus.o_issue, 0);
        chk("hold_rd1_w", bus.o_rd1, 32'h77);
        step();
        bus.i_w_we = 0;
        #1; chk("hold_pc", bus.o_pc, 32'h300); chk("hold_rd1_rf", bus.o_rd1, 32'h77);
        chk("hold_fwd_rf", bus.o_fwd1, 0);
        step();
        bus.i_hold = 0;
        #1; chk("hold_release", bus.o_issue, 1);
        step();

        for (int i = 0; i < 400; i++) begin
            rnd();
            step();
        end

        // Reset mid-stream with cnt[5] = 3 and a live instruction
        idle(); fetch(32'h400); step();
        ctl(0, 0, 0, 0, 1, 5, 3); step();
        ctl(0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        #1;
        chk("mrst_valid", bus.o_valid, 0);
        chk("mrst_inst",  bus.o_inst,  0);
        chk("mrst_pc",    bus.o_pc,    0);
        model_reset();
        idle();
        @(negedge clk);
        rstn = 1'b1;
        fetch(32'h500); step();
        ctl(1, 5, 0, 0, 0, 0, 0);
        #1; chk("mrst_cnt5", bus.o_stall, 0);
        step();
        for (int r = 1; r < NREG; r++) begin
            ctl(1, 5'(r), 1, 5'(NREG - r), 0, 0, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
